// File: rtl/out_uart_tx_if.sv
// Bus bundle between the machine (master) and the OUT-value UART logger (slave).
// The machine side drives out_value/halted; the logger reports line and status.
interface out_uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                      out_value;
  logic                            halted;
  logic                            tx;
  logic                            busy;
  logic                            overflow;
  logic [$clog2(FIFO_DEPTH):0]     fifo_count;

  modport master (
    output out_value,
    output halted,
    input  tx,
    input  busy,
    input  overflow,
    input  fifo_count
  );

  modport slave (
    input  out_value,
    input  halted,
    output tx,
    output busy,
    output overflow,
    output fifo_count
  );
endinterface

// File: rtl/out_uart_tx.sv
// out_uart_tx: watches the machine's OUT value, queues every change in a small
// circular FIFO and serialises each queued byte as an 8N1 UART frame on tx.
// Optional build macro OUT_UART_HALT_MARKER_EN: when defined, a rising edge of
// halted queues a newline byte (8'h0A) after any same-cycle change push.
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  out_uart_tx_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    MARKER     = 8'h0A;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // change detection
  logic [7:0]    prev_r;
  logic          change_s;

  // FIFO
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          room_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [7:0]    push_data_s;
  logic          overflow_r;

  // serialiser
  logic [1:0]    state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic          tx_r;

`ifdef OUT_UART_HALT_MARKER_EN
  logic          halted_d_r;
  logic          marker_pend_r;
  logic          marker_req_s;
  logic          marker_push_s;
`else
  logic          unused_halted_s;
  assign unused_halted_s = bus.halted;
`endif

  // FIFO control: pop whenever the serialiser is idle with data queued;
  // a full FIFO still accepts a push on the same edge it pops.
  always_comb begin
    change_s = (bus.out_value != prev_r);
    full_s   = (count_r == FULL_COUNT);
    pop_s    = (state_r == S_IDLE) && (count_r != {CW{1'b0}});
    room_s   = !full_s || pop_s;
    drop_s   = change_s && !room_s;
`ifdef OUT_UART_HALT_MARKER_EN
    // A change always wins the push slot; the marker waits, never drops.
    marker_req_s  = (bus.halted && !halted_d_r) || marker_pend_r;
    marker_push_s = marker_req_s && !change_s && room_s;
    push_s        = (change_s && room_s) || marker_push_s;
    if (change_s) begin
      push_data_s = bus.out_value;
    end else begin
      push_data_s = MARKER;
    end
`else
    push_s      = change_s && room_s;
    push_data_s = bus.out_value;
`endif
  end

  // Track the previous OUT value; reset captures the live value so it is never sent.
  always_ff @(posedge clk) begin
    prev_r <= bus.out_value;
  end

`ifdef OUT_UART_HALT_MARKER_EN
  // Halt edge detector and pending-marker flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_d_r    <= bus.halted;
      marker_pend_r <= 1'b0;
    end else begin
      halted_d_r    <= bus.halted;
      marker_pend_r <= marker_req_s && !marker_push_s;
    end
  end
`endif

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow: set when a change value is discarded by a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // 8N1 serialiser: START, 8 data bits LSB first, STOP, each CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      baud_r  <= {BW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          baud_r <= {BW{1'b0}};
          bit_r  <= 3'd0;
          if (pop_s) begin
            shift_r <= mem_r[rd_ptr_r];
            tx_r    <= 1'b0;
            state_r <= S_START;
          end else begin
            shift_r <= shift_r;
            tx_r    <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_START: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= {BW{1'b0}};
            tx_r    <= shift_r[0];
            state_r <= S_DATA;
          end else begin
            baud_r  <= baud_r + BW'(1);
            tx_r    <= 1'b0;
            state_r <= S_START;
          end
        end
        S_DATA: begin
          if (baud_r == BAUD_LAST) begin
            baud_r <= {BW{1'b0}};
            if (bit_r == 3'd7) begin
              bit_r   <= 3'd0;
              tx_r    <= 1'b1;
              state_r <= S_STOP;
            end else begin
              bit_r   <= bit_r + 3'd1;
              shift_r <= {1'b0, shift_r[7:1]};
              tx_r    <= shift_r[1];
              state_r <= S_DATA;
            end
          end else begin
            baud_r  <= baud_r + BW'(1);
            state_r <= S_DATA;
          end
        end
        S_STOP: begin
          tx_r <= 1'b1;
          if (baud_r == BAUD_LAST) begin
            baud_r  <= {BW{1'b0}};
            state_r <= S_IDLE;
          end else begin
            baud_r  <= baud_r + BW'(1);
            state_r <= S_STOP;
          end
        end
        default: begin
          state_r <= S_IDLE;
          baud_r  <= {BW{1'b0}};
          bit_r   <= 3'd0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx         = tx_r;
  assign bus.overflow   = overflow_r;
  assign bus.fifo_count = count_r;
  assign bus.busy       = (state_r != S_IDLE) || (count_r != {CW{1'b0}});

endmodule

// File: tb/tb_out_uart_tx.sv
// Directed bench for out_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4). A background
// receiver decodes frames from tx into a queue; the main sequence checks
// waveform timing, FIFO occupancy, overflow, reset and decoded byte order.
module tb_out_uart_tx;

  logic clk = 1'b0;
  logic reset;

  out_uart_tx_if #(.FIFO_DEPTH(4)) u_if ();

  out_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // receiver state
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] frames [$];
  int         stop_errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((u_if.busy !== 1'b0 || rx_active) && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, n < max_cycles}, 32'd1);
    repeat (3) tick();
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp);
    check({tag, "_avail"}, {31'd0, frames.size() != 0}, 32'd1);
    if (frames.size() != 0) begin
      check(tag, {24'd0, frames.pop_front()}, {24'd0, exp});
    end
  endtask

  // Frame receiver: start seen at sample 0, bit i sampled mid-bit at 6+4i, stop at 38.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset === 1'b1) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (u_if.tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0) begin
          rx_byte[(rx_cnt - 6) / 4] = u_if.tx;
        end
        if (rx_cnt == 38) begin
          if (u_if.tx !== 1'b1) stop_errs++;
          frames.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [7:0] a5;
    logic       exp_bit;
    a5 = 8'hA5;

    // 1. reset with 8'h07 present; nothing must ever be sent
    reset = 1'b1;
    u_if.out_value = 8'h07;
    u_if.halted = 1'b0;
    repeat (3) tick();
    check("rst_tx", {31'd0, u_if.tx}, 32'd1);
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_ovf", {31'd0, u_if.overflow}, 32'd0);
    check("rst_cnt", {29'd0, u_if.fifo_count}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("quiet_tx", {31'd0, u_if.tx}, 32'd1);
      check("quiet_busy", {31'd0, u_if.busy}, 32'd0);
    end
    check("quiet_frames", frames.size(), 32'd0);

    // 2. single change to 8'hA5: exact waveform
    u_if.out_value = 8'hA5;
    tick();                                   // edge k: enqueue
    check("a5_k_tx", {31'd0, u_if.tx}, 32'd1);
    check("a5_k_cnt", {29'd0, u_if.fifo_count}, 32'd1);
    check("a5_k_busy", {31'd0, u_if.busy}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();                                 // edges k+1 .. k+40
      if (i < 4) exp_bit = 1'b0;
      else if (i < 36) exp_bit = a5[(i - 4) / 4];
      else exp_bit = 1'b1;
      check($sformatf("a5_wave_%0d", i), {31'd0, u_if.tx}, {31'd0, exp_bit});
    end
    check("a5_busy_last", {31'd0, u_if.busy}, 32'd1);
    tick();                                   // edge k+41
    check("a5_busy_done", {31'd0, u_if.busy}, 32'd0);
    repeat (3) tick();
    check_frame("a5_frame", 8'hA5);

    // 3. six distinct values on consecutive edges while idle
    u_if.out_value = 8'h11; tick();
    check("six_cnt1", {29'd0, u_if.fifo_count}, 32'd1);
    u_if.out_value = 8'h22; tick();
    check("six_cnt2", {29'd0, u_if.fifo_count}, 32'd1);
    u_if.out_value = 8'h33; tick();
    check("six_cnt3", {29'd0, u_if.fifo_count}, 32'd2);
    u_if.out_value = 8'h44; tick();
    check("six_cnt4", {29'd0, u_if.fifo_count}, 32'd3);
    u_if.out_value = 8'h55; tick();
    check("six_cnt5", {29'd0, u_if.fifo_count}, 32'd4);
    check("six_ovf_before", {31'd0, u_if.overflow}, 32'd0);
    u_if.out_value = 8'h66; tick();
    check("six_cnt6", {29'd0, u_if.fifo_count}, 32'd4);
    check("six_ovf", {31'd0, u_if.overflow}, 32'd1);
    wait_idle(400);
    check_frame("six_f1", 8'h11);
    check_frame("six_f2", 8'h22);
    check_frame("six_f3", 8'h33);
    check_frame("six_f4", 8'h44);
    check_frame("six_f5", 8'h55);
    check("six_no_extra", frames.size(), 32'd0);
    check("six_ovf_sticky", {31'd0, u_if.overflow}, 32'd1);

    // 4. reset during data bit 3 of 8'hC3 (bit 3 is 0)
    u_if.out_value = 8'hC3; tick();           // edge k
    tick();                                   // edge k+1: start
    repeat (17) tick();                       // inside bit 3
    check("mid_tx_bit3", {31'd0, u_if.tx}, 32'd0);
    reset = 1'b1; tick();
    check("mid_rst_tx", {31'd0, u_if.tx}, 32'd1);
    check("mid_rst_cnt", {29'd0, u_if.fifo_count}, 32'd0);
    check("mid_rst_ovf", {31'd0, u_if.overflow}, 32'd0);
    check("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("post_rst_tx", {31'd0, u_if.tx}, 32'd1);
    end
    check("post_rst_frames", frames.size(), 32'd0);

    // 5. equal value written twice gives one frame
    u_if.out_value = 8'h10; tick();
    u_if.out_value = 8'h10; repeat (3) tick();
    wait_idle(200);
    check_frame("dup_frame", 8'h10);
    check("dup_single", frames.size(), 32'd0);

    // push and pop on the same edge while full
    u_if.out_value = 8'h21; tick();           // edge k
    u_if.out_value = 8'h22; tick();           // k+1 pop 21
    u_if.out_value = 8'h23; tick();
    u_if.out_value = 8'h24; tick();
    u_if.out_value = 8'h25; tick();           // k+4 full
    repeat (37) tick();                       // after k+41, idle
    check("pp_full_cnt", {29'd0, u_if.fifo_count}, 32'd4);
    u_if.out_value = 8'h26; tick();           // k+42 pop and push
    check("pp_cnt_same", {29'd0, u_if.fifo_count}, 32'd4);
    check("pp_no_ovf", {31'd0, u_if.overflow}, 32'd0);
    wait_idle(600);
    check_frame("pp_f1", 8'h21);
    check_frame("pp_f2", 8'h22);
    check_frame("pp_f3", 8'h23);
    check_frame("pp_f4", 8'h24);
    check_frame("pp_f5", 8'h25);
    check_frame("pp_f6", 8'h26);

    // 6. change and halt rise on the same edge
    u_if.out_value = 8'h03;
    u_if.halted = 1'b1;
    tick();
    check("halt_cnt_k", {29'd0, u_if.fifo_count}, 32'd1);
    tick();
`ifdef OUT_UART_HALT_MARKER_EN
    check("halt_cnt_k1", {29'd0, u_if.fifo_count}, 32'd1);
`else
    check("halt_cnt_k1", {29'd0, u_if.fifo_count}, 32'd0);
`endif
    wait_idle(300);
    check_frame("halt_f1", 8'h03);
`ifdef OUT_UART_HALT_MARKER_EN
    check_frame("halt_marker", 8'h0A);
`endif
    check("halt_no_extra", frames.size(), 32'd0);
    check("halt_ovf", {31'd0, u_if.overflow}, 32'd0);

    check("stop_bits", stop_errs, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
